bp_update_scheduler: RTL and testbench

// Sequencer/arbiter for the single-port 2-bit pattern history table (PHT) of the bimodal predictor.

---
 rtl/bp_update_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// Single-port PHT sequencer: post-reset table init, fetch lookups, queued read-modify-write updates.
// Optional performance counters are built when BP_PERF_COUNTERS_EN is defined.
module bp_update_scheduler #(
   parameter int unsigned ADDRESS_WIDTH = 22,
   parameter int unsigned INDEX_BITS    = 7,
   parameter int unsigned QUEUE_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT  = 3,
   parameter logic [1:0]  INIT_VALUE    = 2'b11
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset_n,
   input  logic [ADDRESS_WIDTH-1:0] i_IMEM_address,
   input  logic                     i_IMEM_isbranch,
   input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
   input  logic                     i_ALU_isbranch,
   input  logic                     i_ALU_outcome,
   input  logic                     i_ALU_prediction,
   input  logic [1:0]               i_PHT_rdata,
   output logic [INDEX_BITS-1:0]    o_PHT_addr,
   output logic                     o_PHT_we,
   output logic [1:0]               o_PHT_wdata,
   output logic                     o_taken,
   output logic                     o_valid,
   output logic                     o_stall,
   output logic                     o_flush,
   output logic                     o_drop,
   output logic [31:0]              o_pred_count,
   output logic [31:0]              o_mispred_count
);

   localparam int unsigned PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int unsigned ENTRY_W  = INDEX_BITS + 1;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_RD, S_UPD_WR} state_t;

   state_t                state_q, state_d;
   logic [INDEX_BITS-1:0] init_idx_q;
   logic [ENTRY_W-1:0]    fifo_mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [STARVE_W-1:0]   starve_q;
   logic [1:0]            rd_val_q;
   logic [1:0]            upd_wdata;
   logic                  flush_q, drop_q;

   logic [ENTRY_W-1:0]    head;
   logic [INDEX_BITS-1:0] head_idx;
   logic                  head_out;
   logic                  fifo_nonempty, fifo_full, starve_hit;
   logic                  fetch_grant, push_req, push, pop;
   logic                  unused_pc_bits;

   // Only the low PC bits index the table.
   assign unused_pc_bits = ^{i_IMEM_address[ADDRESS_WIDTH-1:INDEX_BITS],
                             i_ALU_pc[ADDRESS_WIDTH-1:INDEX_BITS]};

   assign head          = fifo_mem[rd_ptr_q];
   assign head_idx      = head[ENTRY_W-1:1];
   assign head_out      = head[0];
   assign fifo_nonempty = (count_q != '0);
   assign fifo_full     = (count_q == CNT_W'(QUEUE_DEPTH));
   assign starve_hit    = (starve_q == STARVE_W'(STARVE_LIMIT));
   assign fetch_grant   = (state_q == S_IDLE) && i_IMEM_isbranch && !(fifo_nonempty && starve_hit);
   assign pop           = (state_q == S_UPD_WR);
   assign push_req      = i_ALU_isbranch && (state_q != S_INIT);
   // A full queue still accepts when the head is retired in the same cycle.
   assign push          = push_req && (!fifo_full || pop);

   assign o_taken = o_valid & i_PHT_rdata[1];
   assign o_flush = flush_q;
   assign o_drop  = drop_q;

   // Saturating 2-bit counter step for the head update.
   always_comb begin
      upd_wdata = rd_val_q;
      if (head_out) begin
         if (rd_val_q != 2'b11) upd_wdata = rd_val_q + 2'd1;
      end else if (rd_val_q != 2'b00) begin
         upd_wdata = rd_val_q - 2'd1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) state_q <= S_INIT;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT:   if (init_idx_q == '1) state_d = S_IDLE;
         S_IDLE:   if (!fetch_grant && fifo_nonempty) state_d = S_UPD_RD;
         S_UPD_RD: state_d = S_UPD_WR;
         S_UPD_WR: state_d = S_IDLE;
         default:  state_d = S_INIT;
      endcase
   end

   // Port steering; write enable is held low while reset is asserted.
   always_comb begin
      o_PHT_addr  = '0;
      o_PHT_we    = 1'b0;
      o_PHT_wdata = 2'b00;
      o_valid     = 1'b0;
      o_stall     = 1'b1;
      unique case (state_q)
         S_INIT: begin
            o_PHT_we    = i_Reset_n;
            o_PHT_addr  = init_idx_q;
            o_PHT_wdata = INIT_VALUE;
         end
         S_IDLE: begin
            if (fetch_grant) begin
               o_PHT_addr = i_IMEM_address[INDEX_BITS-1:0];
               o_valid    = 1'b1;
               o_stall    = 1'b0;
            end else if (fifo_nonempty) begin
               o_PHT_addr = head_idx;
            end else begin
               o_stall = 1'b0;
            end
         end
         S_UPD_RD: o_PHT_addr = head_idx;
         S_UPD_WR: begin
            o_PHT_we    = 1'b1;
            o_PHT_addr  = head_idx;
            o_PHT_wdata = upd_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {i_ALU_pc[INDEX_BITS-1:0], i_ALU_outcome};
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         init_idx_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         rd_val_q   <= 2'b00;
         flush_q    <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         if (state_q == S_INIT)   init_idx_q <= init_idx_q + INDEX_BITS'(1);
         if (state_q == S_UPD_RD) rd_val_q   <= i_PHT_rdata;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (!push && pop) count_q <= count_q - CNT_W'(1);
         if (pop)                                             starve_q <= '0;
         else if (fetch_grant && fifo_nonempty && !starve_hit) starve_q <= starve_q + STARVE_W'(1);
         flush_q <= i_ALU_isbranch && (i_ALU_outcome != i_ALU_prediction);
         drop_q  <= push_req && fifo_full && !pop;
      end
   end

`ifdef BP_PERF_COUNTERS_EN
   logic [31:0] pred_cnt_q, mispred_cnt_q;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         pred_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (o_valid) pred_cnt_q    <= pred_cnt_q + 32'd1;
         if (flush_q) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign o_pred_count    = pred_cnt_q;
   assign o_mispred_count = mispred_cnt_q;
`else
   assign o_pred_count    = 32'd0;
   assign o_mispred_count = 32'd0;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed + random bench for bp_update_scheduler against a queue-based reference model.
module tb_bp_update_scheduler;
   localparam int unsigned AW = 22;
   localparam int unsigned IB = 7;
   localparam int          QD = 4;
   localparam int          SL = 3;
   localparam int          N  = 128;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] imem_address;
   logic          imem_isbranch;
   logic [AW-1:0] alu_pc;
   logic          alu_isbranch, alu_outcome, alu_prediction;
   logic [1:0]    pht_rdata;
   logic [IB-1:0] pht_addr;
   logic          pht_we;
   logic [1:0]    pht_wdata;
   logic          taken, valid, stall, flush, drop;
   logic [31:0]   pred_count, mispred_count;

   bp_update_scheduler dut (
      .i_Clk(clk), .i_Reset_n(rst_n),
      .i_IMEM_address(imem_address), .i_IMEM_isbranch(imem_isbranch),
      .i_ALU_pc(alu_pc), .i_ALU_isbranch(alu_isbranch),
      .i_ALU_outcome(alu_outcome), .i_ALU_prediction(alu_prediction),
      .i_PHT_rdata(pht_rdata), .o_PHT_addr(pht_addr), .o_PHT_we(pht_we),
      .o_PHT_wdata(pht_wdata), .o_taken(taken), .o_valid(valid), .o_stall(stall),
      .o_flush(flush), .o_drop(drop), .o_pred_count(pred_count),
      .o_mispred_count(mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Table storage with combinational read.
   logic [1:0] pht [N];
   assign pht_rdata = pht[pht_addr];
   always @(posedge clk) if (pht_we) pht[pht_addr] <= pht_wdata;

   typedef struct {int idx; bit outc;} upd_t;
   upd_t        q[$];
   logic [1:0]  ref_tbl [N];
   int          init_left, phase, starve;
   bit          exp_flush, exp_drop;
   int unsigned exp_pred, exp_mis;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      init_left = N; q.delete(); phase = 0; starve = 0;
      exp_flush = 0; exp_drop = 0; exp_pred = 0; exp_mis = 0;
   endtask

   // One cycle: drive at negedge, check 1 time unit later, then advance the model.
   task automatic step(input bit freq, input int fpc, input bit av, input int apc,
                       input bit aout, input bit apred);
      bit e_we, e_valid, e_stall, e_taken, ck_addr, ck_wd, grant, popping, was_init, ndrop;
      int e_addr, qsz;
      logic [1:0] e_wd, v;
      imem_isbranch = freq; imem_address = AW'(fpc);
      alu_isbranch = av; alu_pc = AW'(apc); alu_outcome = aout; alu_prediction = apred;
      #1;
      e_we = 0; e_valid = 0; e_stall = 1; e_taken = 0; ck_addr = 0; ck_wd = 0;
      grant = 0; popping = 0; e_addr = 0; e_wd = 2'b00;
      qsz = q.size();
      was_init = (init_left > 0);
      if (was_init) begin
         e_we = 1; e_addr = N - init_left; e_wd = 2'b11; ck_addr = 1; ck_wd = 1;
      end else if (phase == 1) begin
         e_addr = q[0].idx; ck_addr = 1;
      end else if (phase == 2) begin
         v = ref_tbl[q[0].idx];
         e_we = 1; e_addr = q[0].idx; ck_addr = 1; ck_wd = 1; popping = 1;
         if (q[0].outc) e_wd = (v == 2'b11) ? v : v + 2'd1;
         else           e_wd = (v == 2'b00) ? v : v - 2'd1;
      end else begin
         grant = freq && !(qsz > 0 && starve == SL);
         if (grant) begin
            e_valid = 1; e_stall = 0; e_addr = fpc % N; ck_addr = 1;
            v = ref_tbl[e_addr]; e_taken = v[1];
         end else begin
            e_stall = (qsz > 0);
         end
      end
      chk("we", 32'(pht_we), 32'(e_we));
      chk("valid", 32'(valid), 32'(e_valid));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("taken", 32'(taken), 32'(e_taken));
      chk("flush", 32'(flush), 32'(exp_flush));
      chk("drop", 32'(drop), 32'(exp_drop));
      chk("pred_count", pred_count, exp_pred);
      chk("mispred_count", mispred_count, exp_mis);
      if (ck_addr) chk("addr", 32'(pht_addr), 32'(e_addr));
      if (ck_wd)   chk("wdata", 32'(pht_wdata), 32'(e_wd));

      ndrop = 0;
      if (was_init) begin
         ref_tbl[e_addr] = 2'b11; init_left--;
      end else if (phase == 1) begin
         phase = 2;
      end else if (phase == 2) begin
         ref_tbl[q[0].idx] = e_wd;
      end else if (grant) begin
         if (qsz > 0 && starve < SL) starve++;
      end else if (qsz > 0) begin
         phase = 1;
      end
      if (popping) begin
         void'(q.pop_front()); starve = 0; phase = 0;
      end
      if (!was_init && av) begin
         if (qsz < QD || popping) q.push_back('{idx: apc % N, outc: aout});
         else ndrop = 1;
      end
`ifdef BP_PERF_COUNTERS_EN
      if (e_valid) exp_pred++;
      if (exp_flush) exp_mis++;
`endif
      exp_flush = av && (aout != apred);
      exp_drop  = ndrop;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_isbranch = 0; alu_isbranch = 0;
      #1;
      chk("rst_we", 32'(pht_we), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_stall", 32'(stall), 32'd1);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      chk("rst_taken", 32'(taken), 32'd0);
      chk("rst_pred", pred_count, 32'd0);
      chk("rst_mispred", mispred_count, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      imem_isbranch = 0; imem_address = '0;
      alu_isbranch = 0; alu_pc = '0; alu_outcome = 0; alu_prediction = 0;
      for (int k = 0; k < N; k++) begin pht[k] = 2'b00; ref_tbl[k] = 2'b00; end
      #2;
      do_reset();

      // Table init then idle.
      idle(N + 2);
      for (int k = 0; k < N; k++) chk("init_tbl", 32'(pht[k]), 32'd3);

      // Lookup at 5, mispredicted not-taken resolution.
      step(1, 5, 0, 0, 0, 0);
      step(0, 0, 1, 5, 0, 1);
      idle(4);
      chk("pht5", 32'(pht[5]), 32'd2);
      step(1, 32'h300005, 0, 0, 0, 0);

      // Saturation at both ends.
      step(0, 0, 1, 0, 1, 1); idle(3);
      step(0, 0, 1, 0, 1, 1); idle(3);
      chk("pht0_sat", 32'(pht[0]), 32'd3);
      for (int k = 0; k < 4; k++) step(0, 0, 1, 3, 0, 0);
      idle(12);
      chk("pht3_sat", 32'(pht[3]), 32'd0);

      // Starvation: one queued update under continuous fetch.
      step(1, 16, 1, 9, 1, 1);
      for (int k = 0; k < 10; k++) step(1, 16 + k, 0, 0, 0, 0);

      // Queue overflow under continuous fetch.
      for (int k = 0; k < 5; k++) step(1, 40, 1, 20 + k, k % 2, 0);
      for (int k = 0; k < 24; k++) step(1, 41, 0, 0, 0, 0);
      chk("pht20", 32'(pht[20]), 32'd2);
      chk("pht21", 32'(pht[21]), 32'd3);

      // Random traffic.
      for (int c = 0; c < 400; c++)
         step($urandom_range(0, 9) < 7, int'($urandom & 32'h3FFFFF),
              $urandom_range(0, 9) < 4, int'($urandom & 32'h3FFFFF),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(30);
      for (int k = 0; k < N; k++) chk("tbl_rand", 32'(pht[k]), 32'(ref_tbl[k]));

      // Reset while an update is in its read phase.
      step(0, 0, 1, 7, 0, 0);
      for (int k = 0; k < 10 && phase != 1; k++) idle(1);
      chk("reach_rd", 32'(phase), 32'd1);
      do_reset();
      idle(N + 3);
      for (int k = 0; k < N; k++) chk("reinit_tbl", 32'(pht[k]), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
